pic_init_sequencer: RTL

Clocked command sequencer in front of the PIC control logic. Detects CPU write strobes and classifies each write as ICW1–ICW4 or OCW1–OCW3 using the A0 line, the data bits and the initialization state. Stores the resulting configuration and drives the `WR_cur`-style command code, data and strobes that configure the control logic, IMR and IRR. Also qualifies CPU reads into a registered read flag.

---
 rtl/pic_init_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer
// Turns raw CPU bus writes into classified ICW/OCW commands for the PIC core.
// Holds the resulting configuration registers and the init state machine.
// Also produces a registered read qualifier.
module pic_init_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [2:0] wr_cur,
  output logic       wr_strobe,
  output logic [7:0] ds_out,
  output logic       init_reset,
  output logic       init_done,
  output logic       sngl,
  output logic       ltim,
  output logic       ic4,
  output logic       no_icw4,
  output logic [4:0] vector_base,
  output logic [7:0] icw3_val,
  output logic       aeoi,
  output logic [7:0] imr,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       ocw2_strobe,
  output logic       rd_sel,
  output logic       rd_flag
);

  localparam logic [2:0] CMD_ICW1 = 3'b000;
  localparam logic [2:0] CMD_ICW2 = 3'b001;
  localparam logic [2:0] CMD_ICW3 = 3'b010;
  localparam logic [2:0] CMD_ICW4 = 3'b011;
  localparam logic [2:0] CMD_OCW1 = 3'b100;
  localparam logic [2:0] CMD_OCW2 = 3'b101;
  localparam logic [2:0] CMD_OCW3 = 3'b110;
  localparam logic [2:0] CMD_NONE = 3'b111;

  localparam logic [2:0] S_WAIT_ICW1 = 3'd0;
  localparam logic [2:0] S_WAIT_ICW2 = 3'd1;
  localparam logic [2:0] S_WAIT_ICW3 = 3'd2;
  localparam logic [2:0] S_WAIT_ICW4 = 3'd3;
  localparam logic [2:0] S_READY     = 3'd4;

  logic [2:0] state_q, state_d;
  logic       wr_q;
  logic       cap_q;
  logic       a0_q;
  logic [7:0] din_q;
  logic       commit;
  logic       accept;
  logic [2:0] code;

  logic [2:0] wr_cur_q;
  logic       wr_strobe_q, init_reset_q, ocw2_strobe_q;
  logic [7:0] ds_out_q, icw3_q, imr_q;
  logic       sngl_q, ltim_q, ic4_q, aeoi_q, rd_sel_q, rd_flag_q;
  logic [4:0] vector_base_q;
  logic [2:0] ocw2_cmd_q, ocw2_level_q;

  // Hold the last byte seen while selected and write is low; a deselect during the low phase drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= 1'b1;
      cap_q <= 1'b0;
      a0_q  <= 1'b0;
      din_q <= 8'h00;
    end else begin
      wr_q <= wr_n;
      if (!wr_n) begin
        cap_q <= !cs_n;
        if (!cs_n) begin
          a0_q  <= a0;
          din_q <= din;
        end
      end else begin
        cap_q <= 1'b0;
      end
    end
  end

  // Classify the held write on the rising edge of wr_n and pick the next init state
  always_comb begin
    commit  = !wr_q && wr_n && cap_q;
    accept  = 1'b0;
    code    = CMD_NONE;
    state_d = state_q;
    if (commit) begin
      if (!a0_q && din_q[4]) begin
        accept  = 1'b1;
        code    = CMD_ICW1;
        state_d = S_WAIT_ICW2;
      end else begin
        case (state_q)
          S_WAIT_ICW2: if (a0_q) begin
            accept  = 1'b1;
            code    = CMD_ICW2;
            state_d = !sngl_q ? S_WAIT_ICW3 : (ic4_q ? S_WAIT_ICW4 : S_READY);
          end
          S_WAIT_ICW3: if (a0_q) begin
            accept  = 1'b1;
            code    = CMD_ICW3;
            state_d = ic4_q ? S_WAIT_ICW4 : S_READY;
          end
          S_WAIT_ICW4: if (a0_q) begin
            accept  = 1'b1;
            code    = CMD_ICW4;
            state_d = S_READY;
          end
          S_READY: begin
            accept = 1'b1;
            code   = a0_q ? CMD_OCW1 : (din_q[3] ? CMD_OCW3 : CMD_OCW2);
          end
          default: ;
        endcase
      end
    end
  end

  // Apply accepted commands to the configuration registers and fire the one-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_WAIT_ICW1;
      wr_cur_q      <= CMD_NONE;
      ds_out_q      <= 8'h00;
      wr_strobe_q   <= 1'b0;
      init_reset_q  <= 1'b0;
      ocw2_strobe_q <= 1'b0;
      sngl_q        <= 1'b0;
      ltim_q        <= 1'b0;
      ic4_q         <= 1'b0;
      aeoi_q        <= 1'b0;
      vector_base_q <= 5'd0;
      icw3_q        <= 8'h00;
      imr_q         <= 8'h00;
      ocw2_cmd_q    <= 3'd0;
      ocw2_level_q  <= 3'd0;
      rd_sel_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_strobe_q   <= accept;
      init_reset_q  <= accept && (code == CMD_ICW1);
      ocw2_strobe_q <= accept && (code == CMD_OCW2);
      if (accept) begin
        wr_cur_q <= code;
        ds_out_q <= din_q;
        case (code)
          CMD_ICW1: begin
            ltim_q        <= din_q[3];
            sngl_q        <= din_q[1];
            ic4_q         <= din_q[0];
            imr_q         <= 8'h00;
            aeoi_q        <= 1'b0;
            ocw2_cmd_q    <= 3'd0;
            ocw2_level_q  <= 3'd0;
            vector_base_q <= 5'd0;
            icw3_q        <= 8'h00;
            rd_sel_q      <= 1'b0;
          end
          CMD_ICW2: vector_base_q <= din_q[7:3];
          CMD_ICW3: icw3_q <= din_q;
          CMD_ICW4: aeoi_q <= din_q[1];
          CMD_OCW1: imr_q <= din_q;
          CMD_OCW2: begin
            ocw2_cmd_q   <= din_q[7:5];
            ocw2_level_q <= din_q[2:0];
          end
          CMD_OCW3: if (din_q[1]) rd_sel_q <= din_q[0];
          default: ;
        endcase
      end
    end
  end

  // Qualify CPU reads only once initialization is complete and no write is in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_flag_q <= 1'b0;
    else     rd_flag_q <= !cs_n && !rd_n && wr_n && (state_q == S_READY);
  end

  assign wr_cur      = wr_cur_q;
  assign wr_strobe   = wr_strobe_q;
  assign ds_out      = ds_out_q;
  assign init_reset  = init_reset_q;
  assign init_done   = (state_q == S_READY);
  assign sngl        = sngl_q;
  assign ltim        = ltim_q;
  assign ic4         = ic4_q;
  assign no_icw4     = !ic4_q;
  assign vector_base = vector_base_q;
  assign icw3_val    = icw3_q;
  assign aeoi        = aeoi_q;
  assign imr         = imr_q;
  assign ocw2_cmd    = ocw2_cmd_q;
  assign ocw2_level  = ocw2_level_q;
  assign ocw2_strobe = ocw2_strobe_q;
  assign rd_sel      = rd_sel_q;
  assign rd_flag     = rd_flag_q;

endmodule
